step_input_cond: RTL and testbench

STEP_INPUT_COND -- requirements
Module: step_input_cond

---
 rtl/step_io_pkg.sv | 15 +
 rtl/debounce.sv | 51 +++++
 rtl/step_input_cond.sv | 121 ++++++++++++
 tb/tb_step_input_cond.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/step_io_pkg.sv
// Shared defaults and widths for the step-input front end and the FSM top that consumes it.
package step_io_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int unsigned AUTO_PERIOD_DEF     = 50_000_000;
  localparam int unsigned STEP_CNT_W          = 8;

  typedef logic [STEP_CNT_W-1:0] step_cnt_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw asynchronous input.
// Latency: CYCLES+2 edges from first sample to level_o; free-running, no backpressure.
module debounce
  import step_io_pkg::*;
#(
  parameter int unsigned CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned      CNT_W    = cnt_width(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      level_q <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample agreeing with the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/step_input_cond.sv
// Conditions raw button/switch/mode inputs into a one-cycle step enable, data level and step count.
// Latency: press to en is DEBOUNCE_CYCLES+3 edges, auto pulses every AUTO_PERIOD; no backpressure.
module step_input_cond
  import step_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_step_n,
  input  logic                  sw_a,
  input  logic                  auto_mode,
  output logic                  en,
  output logic                  a,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  localparam int unsigned      PRE_W    = cnt_width(AUTO_PERIOD);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_PERIOD - 1);

  // A button held through reset reaches the debounced level no later than SETTLE edges after release.
  localparam int unsigned      SETTLE      = DEBOUNCE_CYCLES + 2;
  localparam int unsigned      SETTLE_W    = cnt_width(SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE);

  logic                btn_n_lvl;
  logic                sw_lvl;
  logic                pressed;
  logic                auto_s1_q, auto_s2_q;
  logic                prev_q;
  logic                armed_q, armed_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                wrap;
  logic                en_q, en_d;
  step_cnt_t           cnt_q, cnt_d;

  debounce #(
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (1'b1)
  ) u_db_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (btn_step_n),
    .level_o (btn_n_lvl)
  );

  debounce #(
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (1'b0)
  ) u_db_sw (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (sw_a),
    .level_o (sw_lvl)
  );

  assign pressed = ~btn_n_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= '0;
      pre_q     <= '0;
      en_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      auto_s1_q <= auto_mode;
      auto_s2_q <= auto_s1_q;
      prev_q    <= pressed;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
      pre_q     <= pre_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    settle_d = settle_q;
    if (settle_q != SETTLE_LAST) begin
      settle_d = settle_q + SETTLE_W'(1);
    end

    // Manual presses only count once the button has been seen released after reset.
    armed_d = armed_q | ((settle_q == SETTLE_LAST) & ~pressed);

    pre_d = '0;
    wrap  = 1'b0;
    if (auto_s2_q) begin
      if (pre_q == PRE_LAST) begin
        wrap = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    if (auto_s2_q) begin
      en_d = wrap;
    end else begin
      en_d = pressed & ~prev_q & armed_q;
    end
    if (en_q) begin
      en_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (en_q) begin
      cnt_d = cnt_q + step_cnt_t'(1);
    end
  end

  assign en       = en_q;
  assign a        = sw_lvl;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_step_input_cond.sv
// Directed bench for step_input_cond at DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
module tb_step_input_cond;

  logic       clk;
  logic       rst_n;
  logic       btn_step_n;
  logic       sw_a;
  logic       auto_mode;
  logic       en;
  logic       a;
  logic [7:0] step_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int en_consec = 0;
  logic en_prev = 1'b0;

  step_input_cond #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_PERIOD     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_step_n (btn_step_n),
    .sw_a       (sw_a),
    .auto_mode  (auto_mode),
    .en         (en),
    .a          (a),
    .step_cnt   (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en && en_prev) en_consec++;
    en_prev = en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Samples en on n successive negedges; k counts edges since the last input change.
  task automatic watch_en(input int n, output int pulses, output int first, output int last);
    pulses = 0;
    first  = 0;
    last   = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (en) begin
        pulses++;
        if (first == 0) first = k;
        last = k;
      end
    end
  endtask

  int p, f, l;
  int lows;
  int cnt_at_last;

  initial begin
    rst_n      = 1'b0;
    btn_step_n = 1'b1;
    sw_a       = 1'b0;
    auto_mode  = 1'b0;
    tick(3);
    check("rst_en", en, 0);
    check("rst_a", a, 0);
    check("rst_cnt", step_cnt, 0);
    rst_n = 1'b1;
    tick(12);

    // Bounce: 2 low, 2 high, three times, then released
    p = 0;
    for (int i = 0; i < 12; i++) begin
      btn_step_n = ((i / 2) % 2) == 1;
      @(negedge clk);
      if (en) p++;
    end
    btn_step_n = 1'b1;
    watch_en(12, f, l, lows);
    check("bounce_pulses", p + f, 0);
    check("bounce_cnt", step_cnt, 0);

    // Clean press
    btn_step_n = 1'b0;
    watch_en(20, p, f, l);
    check("press_pulses", p, 1);
    check("press_latency", f, 7);
    check("press_cnt", step_cnt, 1);
    btn_step_n = 1'b1;
    watch_en(12, p, f, l);
    check("release_pulses", p, 0);
    check("release_cnt", step_cnt, 1);

    // Switch rise and short glitch
    sw_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) check("sw_a_edge5", a, 0);
      if (k == 6) check("sw_a_edge6", a, 1);
    end
    tick(4);
    sw_a = 1'b0;
    tick(3);
    sw_a = 1'b1;
    lows = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!a) lows++;
    end
    check("glitch_lows", lows, 0);
    check("glitch_a", a, 1);

    // Auto mode with the button held; auto dropped after 36 samples
    auto_mode  = 1'b1;
    btn_step_n = 1'b0;
    p = 0; f = 0; l = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (en) begin
        p++;
        if (f == 0) f = k;
        l = k;
      end
      if (k == 36) auto_mode = 1'b0;
    end
    check("auto_pulses", p, 4);
    check("auto_first", f, 10);
    check("auto_last", l, 34);
    check("auto_cnt", step_cnt, 5);

    // Reset at prescaler=5 with the button held
    auto_mode = 1'b1;
    watch_en(15, p, f, l);
    check("pre_rst_pulses", p, 1);
    check("pre_rst_first", f, 10);
    check("pre_rst_cnt", step_cnt, 6);
    rst_n     = 1'b0;
    auto_mode = 1'b0;
    #1;
    check("arst_en", en, 0);
    check("arst_a", a, 0);
    check("arst_cnt", step_cnt, 0);
    tick(3);
    rst_n = 1'b1;
    #1;
    check("rel_en", en, 0);
    check("rel_a", a, 0);
    check("rel_cnt", step_cnt, 0);
    watch_en(30, p, f, l);
    check("held_after_rst", p, 0);
    btn_step_n = 1'b1;
    watch_en(12, p, f, l);
    check("release_after_rst", p, 0);
    btn_step_n = 1'b0;
    watch_en(20, p, f, l);
    check("repress_pulses", p, 1);
    check("repress_latency", f, 7);
    check("repress_cnt", step_cnt, 1);

    // Step counter wrap over 256 auto pulses
    btn_step_n = 1'b1;
    rst_n      = 1'b0;
    tick(1);
    rst_n     = 1'b1;
    auto_mode = 1'b1;
    p = 0;
    cnt_at_last = -1;
    for (int k = 0; k < 2400 && p < 256; k++) begin
      @(negedge clk);
      if (en) begin
        p++;
        if (p == 256) cnt_at_last = step_cnt;
      end
    end
    check("wrap_pulses", p, 256);
    check("wrap_cnt_255", cnt_at_last, 255);
    @(negedge clk);
    check("wrap_cnt_0", step_cnt, 0);
    auto_mode = 1'b0;
    tick(4);

    check("en_consecutive", en_consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
